// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that multiplexes NREQ requesters onto one synchronous RAM port.
// Grants and the RAM port are registered; read data comes back with a one-hot rvalid.
module ram_port_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_din,
  input  logic [DW-1:0]      ram_rdata,
  output logic               busy
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rd_pend_q, rd_pend_d;
  logic [NREQ-1:0] rvalid_q;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_din_q, ram_din_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] elig;
  logic [PW-1:0]   win;
  logic            found;

  // The requester granted last cycle is masked while it drops or re-issues req.
  assign elig = req & ~gnt_q;

  always_comb begin : arbitrate
    logic [PW:0] pos;
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_q} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      if (!found && elig[pos[PW-1:0]]) begin
        found = 1'b1;
        win   = pos[PW-1:0];
      end
    end
  end

  always_comb begin : next_state
    gnt_d      = '0;
    rd_pend_d  = '0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ptr_d      = ptr_q;
    if (found) begin
      gnt_d[win]     = 1'b1;
      rd_pend_d[win] = ~req_we[win];
      ram_we_d       = req_we[win];
      ram_addr_d     = req_addr[win*AW +: AW];
      ram_din_d      = req_din[win*DW +: DW];
      ptr_d          = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
    // rd_pend_d is a subset of gnt_d and the next rvalid is rd_pend_q.
    busy_d = (|gnt_d) | (|rd_pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      rd_pend_q  <= '0;
      rvalid_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      rd_pend_q  <= rd_pend_d;
      rvalid_q   <= rd_pend_q;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = ram_rdata;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, then random traffic against a
// transaction-level reference model, with a write-first RAM model on the port.
module tb_ram_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req, req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_din;
  logic [NREQ-1:0]      gnt, rvalid;
  logic [DW-1:0]        rdata;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_din;
  logic [DW-1:0]        ram_rdata;
  logic                 busy;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_din   (req_din),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-first synchronous RAM on the arbitrated port.
  logic [DW-1:0] ram_mem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_rdata         <= ram_din;
    end else begin
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d] at %0t: got %0h want %0h", nm, idx, $time, act, exp);
    end
  endtask

  // Reference model: tracks the last grant as a transaction and replays it on the RAM.
  int            m_gnt_who;
  logic          m_gnt_we;
  int            m_ptr;
  logic          m_ram_we;
  logic [AW-1:0] m_ram_addr;
  logic [DW-1:0] m_ram_din;
  int            m_rv_who;
  logic [DW-1:0] m_rv_data;
  logic [DW-1:0] m_mem [8];

  task automatic model_edge();
    int win;
    int i;
    int nrv;
    logic [DW-1:0] nrd;
    nrv = -1;
    nrd = '0;
    if (m_gnt_who >= 0 && !m_gnt_we) begin
      nrv = m_gnt_who;
      nrd = m_mem[m_ram_addr];
    end
    if (m_ram_we) m_mem[m_ram_addr] = m_ram_din;
    m_rv_who  = nrv;
    m_rv_data = nrd;
    if (rst) begin
      m_gnt_who  = -1;
      m_gnt_we   = 1'b0;
      m_ptr      = 0;
      m_ram_we   = 1'b0;
      m_ram_addr = '0;
      m_ram_din  = '0;
      m_rv_who   = -1;
    end else begin
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (win < 0 && req[i[1:0]] && i != m_gnt_who) win = i;
      end
      m_gnt_who = win;
      if (win >= 0) begin
        m_gnt_we   = req_we[win[1:0]];
        m_ram_we   = req_we[win[1:0]];
        m_ram_addr = req_addr[win*AW +: AW];
        m_ram_din  = req_din[win*DW +: DW];
        m_ptr      = (win + 1) % NREQ;
      end else begin
        m_ram_we = 1'b0;
      end
    end
  endtask

  task automatic check_model(input int idx);
    logic [NREQ-1:0] eg, ev;
    eg = (m_gnt_who >= 0) ? NREQ'(1 << m_gnt_who) : '0;
    ev = (m_rv_who >= 0) ? NREQ'(1 << m_rv_who) : '0;
    check("model gnt", idx, 32'(gnt), 32'(eg));
    check("model rvalid", idx, 32'(rvalid), 32'(ev));
    check("model ram_we", idx, 32'(ram_we), 32'(m_ram_we));
    check("model ram_addr", idx, 32'(ram_addr), 32'(m_ram_addr));
    check("model ram_din", idx, 32'(ram_din), 32'(m_ram_din));
    check("model busy", idx, 32'(busy), 32'(eg != 0 || ev != 0));
    if (ev != 0) check("model rdata", idx, 32'(rdata), 32'(m_rv_data));
  endtask

  task automatic cycle(input int idx);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_model(idx);
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [8:0]  addr;
    logic [23:0] din;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [7:0]  rd;
    logic        rwe;
    logic [2:0]  ra;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] we,
                              input logic [8:0] a, input logic [23:0] d,
                              input logic [2:0] g, input logic [2:0] rv,
                              input logic [7:0] rd, input logic rwe,
                              input logic [2:0] ra, input logic b);
    vec_t v;
    v.rst = r;  v.req = rq; v.we = we; v.addr = a; v.din = d;
    v.gnt = g;  v.rv = rv;  v.rd = rd; v.rwe = rwe; v.ra = ra; v.busy = b;
    return v;
  endfunction

  localparam logic [8:0]  AR = 9'o210;
  localparam logic [23:0] DR = 24'h121110;
  localparam logic [8:0]  A0 = 9'o000;
  localparam logic [23:0] D0 = 24'h000000;

  vec_t tbl [34];

  logic          act    [NREQ];
  logic          r_we   [NREQ];
  logic [AW-1:0] r_addr [NREQ];
  logic [DW-1:0] r_din  [NREQ];
  int            waitc  [NREQ];

  initial begin
    // reset with all requesting; writes preload 0x10/0x11/0x12 into addresses 0/1/2
    tbl[0]  = mk(1'b1, 3'b111, 3'b111, AR, DR, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);
    tbl[1]  = mk(1'b1, 3'b111, 3'b111, AR, DR, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);
    tbl[2]  = mk(1'b0, 3'b111, 3'b111, AR, DR, 3'b001, 3'b000, 8'h00, 1'b1, 3'd0, 1'b1);
    tbl[3]  = mk(1'b0, 3'b110, 3'b111, AR, DR, 3'b010, 3'b000, 8'h00, 1'b1, 3'd1, 1'b1);
    tbl[4]  = mk(1'b0, 3'b100, 3'b111, AR, DR, 3'b100, 3'b000, 8'h00, 1'b1, 3'd2, 1'b1);
    // round-robin reads with req held at 111
    tbl[5]  = mk(1'b0, 3'b111, 3'b000, AR, D0, 3'b001, 3'b000, 8'h00, 1'b0, 3'd0, 1'b1);
    tbl[6]  = mk(1'b0, 3'b111, 3'b000, AR, D0, 3'b010, 3'b001, 8'h10, 1'b0, 3'd1, 1'b1);
    tbl[7]  = mk(1'b0, 3'b111, 3'b000, AR, D0, 3'b100, 3'b010, 8'h11, 1'b0, 3'd2, 1'b1);
    tbl[8]  = mk(1'b0, 3'b111, 3'b000, AR, D0, 3'b001, 3'b100, 8'h12, 1'b0, 3'd0, 1'b1);
    tbl[9]  = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b001, 8'h10, 1'b0, 3'd0, 1'b1);
    tbl[10] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);
    // r1 writes 0xA5 to addr 5, then reads it back
    tbl[11] = mk(1'b0, 3'b010, 3'b010, 9'o050, 24'h00A500, 3'b010, 3'b000, 8'h00, 1'b1, 3'd5, 1'b1);
    tbl[12] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd5, 1'b0);
    tbl[13] = mk(1'b0, 3'b010, 3'b000, 9'o050, D0, 3'b010, 3'b000, 8'h00, 1'b0, 3'd5, 1'b1);
    tbl[14] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b010, 8'hA5, 1'b0, 3'd5, 1'b1);
    tbl[15] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd5, 1'b0);
    // write-read hazard on addr 3
    tbl[16] = mk(1'b0, 3'b011, 3'b001, 9'o033, 24'h00003C, 3'b001, 3'b000, 8'h00, 1'b1, 3'd3, 1'b1);
    tbl[17] = mk(1'b0, 3'b010, 3'b000, 9'o030, D0, 3'b010, 3'b000, 8'h00, 1'b0, 3'd3, 1'b1);
    tbl[18] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b010, 8'h3C, 1'b0, 3'd3, 1'b1);
    tbl[19] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd3, 1'b0);
    // r2 alone, continuous: granted every other cycle
    tbl[20] = mk(1'b0, 3'b100, 3'b000, 9'o200, D0, 3'b100, 3'b000, 8'h00, 1'b0, 3'd2, 1'b1);
    tbl[21] = mk(1'b0, 3'b100, 3'b000, 9'o200, D0, 3'b000, 3'b100, 8'h12, 1'b0, 3'd2, 1'b1);
    tbl[22] = mk(1'b0, 3'b100, 3'b000, 9'o200, D0, 3'b100, 3'b000, 8'h00, 1'b0, 3'd2, 1'b1);
    tbl[23] = mk(1'b0, 3'b100, 3'b000, 9'o200, D0, 3'b000, 3'b100, 8'h12, 1'b0, 3'd2, 1'b1);
    tbl[24] = mk(1'b0, 3'b100, 3'b000, 9'o200, D0, 3'b100, 3'b000, 8'h00, 1'b0, 3'd2, 1'b1);
    tbl[25] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b100, 8'h12, 1'b0, 3'd2, 1'b1);
    tbl[26] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd2, 1'b0);
    // reset right after a read grant: read dropped, pointer back to 0
    tbl[27] = mk(1'b0, 3'b010, 3'b000, 9'o010, D0, 3'b010, 3'b000, 8'h00, 1'b0, 3'd1, 1'b1);
    tbl[28] = mk(1'b1, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);
    tbl[29] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);
    tbl[30] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);
    tbl[31] = mk(1'b0, 3'b111, 3'b000, AR, D0, 3'b001, 3'b000, 8'h00, 1'b0, 3'd0, 1'b1);
    tbl[32] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b001, 8'h10, 1'b0, 3'd0, 1'b1);
    tbl[33] = mk(1'b0, 3'b000, 3'b000, A0, D0, 3'b000, 3'b000, 8'h00, 1'b0, 3'd0, 1'b0);

    m_gnt_who = -1; m_gnt_we = 1'b0; m_ptr = 0; m_ram_we = 1'b0;
    m_ram_addr = '0; m_ram_din = '0; m_rv_who = -1; m_rv_data = '0;
    for (int a = 0; a < 8; a++) m_mem[a] = '0;

    for (int r = 0; r < 34; r++) begin
      rst = tbl[r].rst; req = tbl[r].req; req_we = tbl[r].we;
      req_addr = tbl[r].addr; req_din = tbl[r].din;
      cycle(r);
      check("tbl gnt", r, 32'(gnt), 32'(tbl[r].gnt));
      check("tbl rvalid", r, 32'(rvalid), 32'(tbl[r].rv));
      check("tbl ram_we", r, 32'(ram_we), 32'(tbl[r].rwe));
      check("tbl ram_addr", r, 32'(ram_addr), 32'(tbl[r].ra));
      check("tbl busy", r, 32'(busy), 32'(tbl[r].busy));
      if (tbl[r].rv != 0) check("tbl rdata", r, 32'(rdata), 32'(tbl[r].rd));
    end

    // Random traffic under varying load, with occasional resets.
    for (int i = 0; i < NREQ; i++) begin
      act[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_din[i] = '0; waitc[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      int load;
      load = (c < 1000) ? 90 : (c < 2000) ? 40 : 10;
      rst = (c < 2) || ($urandom_range(299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!act[i] && $urandom_range(99) < load) begin
          act[i]    = 1'b1;
          r_we[i]   = 1'($urandom_range(1));
          r_addr[i] = AW'($urandom_range(7));
          r_din[i]  = DW'($urandom);
        end
        req[i]               = act[i];
        req_we[i]            = r_we[i];
        req_addr[i*AW +: AW] = r_addr[i];
        req_din[i*DW +: DW]  = r_din[i];
      end
      cycle(1000 + c);
      for (int i = 0; i < NREQ; i++) begin
        if (rst) begin
          waitc[i] = 0;
        end else if (gnt[i]) begin
          n_total++;
          if (waitc[i] >= NREQ) begin
            n_bad++;
            $display("FAIL fairness [%0d] r%0d: got %0d other grants want < %0d",
                     c, i, waitc[i], NREQ);
          end
          waitc[i] = 0;
        end else if (act[i] && gnt != 0) begin
          waitc[i]++;
        end
        if (!rst && m_gnt_who == i) act[i] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter sharing one synchronous RAM port (8x8 by default; write-first-at-edge, read data registered) among NREQ requesters.
- Registers the winning request onto the RAM port and returns one-hot read-valid with the RAM's read data.
- Sits between client blocks and one port of the team's dual-port RAM. The other RAM port stays with its own owner.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 3, RAM address width.
- DW, 8, RAM data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  request per requester; held with we/addr/din until its gnt.
- req_we  in  NREQ  1 = write, 0 = read, per requester.
- req_addr  in  NREQ*AW  flattened; requester i at [i*AW +: AW].
- req_din  in  NREQ*DW  flattened write data; requester i at [i*DW +: DW].
- gnt  out  NREQ  one-hot, registered; high 1 cycle = request accepted and on RAM port.
- rvalid  out  NREQ  one-hot; high 1 cycle when rdata holds requester i's read result.
- rdata  out  DW  read data; combinational pass-through of ram_rdata, meaningful only while rvalid != 0.
- ram_we  out  1  registered RAM write enable.
- ram_addr  out  AW  registered RAM address.
- ram_din  out  DW  registered RAM write data.
- ram_rdata  in  DW  RAM registered read output (dout <= mem[addr] each edge).
- busy  out  1  registered; 1 while any gnt or pending read is in flight.

Behaviour:
- Reset (rst=1 at posedge):
  - gnt=0, rvalid=0, ram_we=0, ram_addr=0, ram_din=0, busy=0.
  - Round-robin pointer ptr=0; read-pending register cleared.
  - An in-flight read is dropped and no rvalid is issued for it.
- Eligibility: elig = req & ~gnt. The requester granted this cycle is masked, so no double grant while it drops req.
- Arbitration, each posedge when not in reset:
  - Winner w = first set bit of elig scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - If elig != 0: gnt <= onehot(w); ram_we <= req_we[w]; ram_addr <= addr_w; ram_din <= din_w; ptr <= (w+1) mod NREQ.
  - If elig == 0: gnt <= 0; ram_we <= 0; ram_addr/ram_din hold; ptr holds.
- Timing:
  - Request present before edge E0 -> gnt high after E0 (1 cycle).
  - RAM samples ram_* at E1.
  - For reads, rvalid[w] is high for the cycle after E1, with rdata = mem[addr] (2-cycle request-to-data).
- Read pipeline:
  - rd_pend <= gnt & ~req_we-of-winner, registered with gnt.
  - rvalid <= rd_pend.
  - Writes never produce rvalid.
- Throughput:
  - One access per cycle.
  - Different requesters may be granted back-to-back.
  - The same requester is granted at most every 2nd cycle.
- Ordering: write by A granted at E0 then read of the same address granted at E1 returns the new data. The write lands at E1 and the read samples at E2.
- Fairness: any continuously asserted req is granted within NREQ grant cycles.
- busy = |gnt | |rd_pend | |rvalid, registered.
- Requester protocol violation (changing addr/we/din before gnt) is undefined. The arbiter samples the values present at the granting edge.

Test Plan:
- Reset: assert rst 2 cycles with req=3'b111 -> gnt=0, rvalid=0, ram_we=0, ram_addr=0, busy=0. First grant after release is to requester 0.
- Single write then read: r1 writes addr 5 data 0xA5, then reads addr 5 -> gnt[1] 1 cycle after each req; rvalid=3'b010 two cycles after the read req with rdata=0xA5.
- Round-robin: req=3'b111 held, all reads of addr 0/1/2 preloaded 0x10/0x11/0x12 -> gnt sequence 001,010,100,001. rvalid follows 2 cycles later with 0x10,0x11,0x12.
- Contention with mask: only r2 requests continuously -> gnt[2] every other cycle, never two consecutive cycles.
- Write-read hazard: r0 writes addr 3=0x3C, r1 reads addr 3 granted next cycle -> r1 rvalid with rdata=0x3C.
- Reset mid-operation: rst asserted the cycle after a read grant -> no rvalid ever appears for that read; ptr=0 after reset.
